// File: rtl/instr_count_reader.sv
// Readout engine for the per-opcode instruction counter bank.
// A start request freezes every counter into a local snapshot, then the
// snapshot is streamed to the debug UART transmitter as one framed packet:
//   HDR_BYTE, NUM_CNT, counter bytes (little-endian, counter 0 first), checksum
// The checksum is the 8-bit wrap-around sum of the length byte and all data
// bytes. The live counters keep running while the frame is sent.
module instr_count_reader #(
    parameter int          NUM_CNT  = 18,
    parameter int          CNT_W    = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_flat,
    input  logic                     start,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               checksum
);

    // Width of the counter index; a single-counter build still needs one bit.
    localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    // Length byte carried in the frame right after the header.
    localparam logic [7:0] LEN_BYTE = 8'(NUM_CNT);

    // Index of the final counter, used to leave the payload phase.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t state;
    state_t state_nxt;

    // Frozen copy of the counters; only written when a frame is accepted.
    logic [CNT_W-1:0] snap [NUM_CNT];

    logic [IDX_W-1:0] cnt_idx;
    logic [1:0]       byte_idx;

    logic [CNT_W-1:0] cur_word;
    logic [7:0]       data_byte;
    logic             accept;
    logic             xfer;
    logic             last_byte;

    // A new frame is only taken from IDLE; start during a frame is dropped.
    assign accept    = (state == S_IDLE) && start;

    // A byte leaves on every edge where the handshake completes.
    assign xfer      = tx_valid && tx_ready;

    // Final payload byte: top byte of the last counter.
    assign last_byte = (byte_idx == 2'd3) && (cnt_idx == LAST_IDX);

    // Select the payload byte addressed by the counter and byte indices.
    always_comb begin
        cur_word  = snap[cnt_idx];
        data_byte = 8'h00;
        case (byte_idx)
            2'd0:    data_byte = cur_word[7:0];
            2'd1:    data_byte = cur_word[15:8];
            2'd2:    data_byte = cur_word[23:16];
            default: data_byte = cur_word[31:24];
        endcase
    end

    // Next state and per-state outputs; the byte on tx_data depends only on
    // registered state, so it cannot move while the transmitter stalls.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_nxt = state;
        tx_valid  = 1'b0;
        busy      = 1'b0;
        tx_data   = 8'h00;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = LEN_BYTE;
                if (tx_ready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = data_byte;
                if (tx_ready && last_byte) begin
                    state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = checksum;
                if (tx_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so all flops update from pre-edge values.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture all counters at the accepting edge; held for the whole frame.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the snapshot is reset because it must read as zero after reset,
        // so it cannot map to RAM; it stays as a bank of resettable flops.
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap[i] <= cnt_flat[i*CNT_W +: CNT_W];
            end
        end
    end

    // Walk counter and byte indices across the payload, one step per byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_idx  <= '0;
            byte_idx <= 2'd0;
        end else if (accept || ((state == S_LEN) && xfer)) begin
            cnt_idx  <= '0;
            byte_idx <= 2'd0;
        end else if ((state == S_DATA) && xfer) begin
            byte_idx <= byte_idx + 2'd1;
            if ((byte_idx == 2'd3) && (cnt_idx != LAST_IDX)) begin
                cnt_idx <= cnt_idx + IDX_W'(1);
            end
        end
    end

    // Running checksum over the length byte and payload; held after the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= 8'h00;
        end else if (accept) begin
            checksum <= 8'h00;
        end else if (xfer && ((state == S_LEN) || (state == S_DATA))) begin
            checksum <= checksum + tx_data;
        end
    end

    // One-cycle completion pulse in the cycle after the checksum byte leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_CSUM) && xfer;
        end
    end

endmodule

// File: tb/tb_instr_count_reader.sv
// Self-checking bench for instr_count_reader. The expected frame is built
// from the counter values with plain arithmetic and compared byte for byte
// against what crosses the valid/ready handshake.
module tb_instr_count_reader;

    localparam int NUM_CNT   = 18;
    localparam int FRAME_LEN = 2 + 4*NUM_CNT + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CNT*32-1:0]   cnt_flat;
    logic                    start;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic                    done;
    logic [7:0]              checksum;

    logic [31:0] cnt_val [NUM_CNT];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    int errors = 0;
    int checks = 0;

    instr_count_reader #(
        .NUM_CNT  (NUM_CNT),
        .CNT_W    (32),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cnt_flat (cnt_flat),
        .start    (start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_flat[i*32 +: 32] = cnt_val[i];
        end
    end

    // Reference frame from the current counter values.
    function automatic void build_expected();
        logic [7:0] b;
        logic [7:0] sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NUM_CNT));
        sum = 8'(NUM_CNT);
        for (int i = 0; i < NUM_CNT; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'((cnt_val[i] >> (8*k)) & 32'hFF);
                exp_q.push_back(b);
                sum = sum + b;
            end
        end
        exp_q.push_back(sum);
    endfunction

    // Start a frame and collect transferred bytes into got_q.
    task automatic run_frame(input int ready_pct, input bit bump0, input int restart_at,
                             input int reset_at, input int exp_done,
                             output int done_cnt, output int done_at);
        logic       stall;
        logic [7:0] hold;
        bit         restarted;
        int         cyc;
        int         tail;
        got_q.delete();
        done_cnt  = 0;
        done_at   = -1;
        stall     = 1'b0;
        hold      = 8'h00;
        restarted = 1'b0;
        tail      = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 3000 && tail != 0) begin
            tx_ready = ($urandom_range(99) < ready_pct);
            if (bump0) cnt_val[0] = cnt_val[0] + 32'd1;
            if (exp_done > 1 && done && (done_cnt + 1) < exp_done) start = 1'b1;
            if (restart_at >= 0 && !restarted && got_q.size() == restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (reset_at >= 0 && got_q.size() == reset_at) begin
                reset = 1'b1;
                #1;
                checks++;
                if (tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_valid: tx_valid=%b required 0", tx_valid);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_busy: busy=%b required 0", busy);
                end
                @(posedge clk); #1;
                reset    = 1'b0;
                start    = 1'b0;
                tx_ready = 1'b0;
                return;
            end
            @(negedge clk);
            if (stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== hold) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b data=%h required valid=1 data=%h",
                             tx_valid, tx_data, hold);
                end
            end
            stall = tx_valid && !tx_ready;
            hold  = tx_data;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (tail > 0) tail--;
            if (tail < 0 && done_cnt >= exp_done) tail = 12;
        end
        tx_ready = 1'b0;
        checks++;
        if (done_cnt < exp_done) begin
            errors++;
            $display("FAIL timeout: done pulses=%0d required %0d", done_cnt, exp_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tx_data  !== 8'h00) begin errors++; $display("FAIL rst_tx_data: %h required 00", tx_data); end
        checks++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_tx_valid: %b required 0", tx_valid); end
        checks++; if (busy     !== 1'b0)  begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
        checks++; if (done     !== 1'b0)  begin errors++; $display("FAIL rst_done: %b required 0", done); end
        checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL rst_checksum: %h required 00", checksum); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dc, da, mism;
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = 32'(i) * 32'h0101 + 32'd1;
        build_expected();
        run_frame(100, 1'b0, -1, -1, 1, dc, da);
        checks++;
        if (got_q.size() != FRAME_LEN) begin
            errors++; $display("FAIL basic_len: %0d bytes required %0d", got_q.size(), FRAME_LEN);
        end else begin
            mism = -1;
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i] && mism < 0) mism = i;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL basic_byte: byte %0d=%h required %h", mism, got_q[mism], exp_q[mism]);
            end
        end
        checks++; if (dc != 1)  begin errors++; $display("FAIL basic_done_cnt: %0d required 1", dc); end
        checks++; if (da != 76) begin errors++; $display("FAIL basic_done_time: cycle %0d required 76", da); end
        checks++; if (checksum !== exp_q[$]) begin errors++; $display("FAIL basic_csum_hold: %h required %h", checksum, exp_q[$]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: %b required 0", busy); end
    endtask

    task automatic test_random_ready();
        int dc, da, mism;
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = 32'(i) * 32'h0101 + 32'd1;
        build_expected();
        run_frame(50, 1'b0, -1, -1, 1, dc, da);
        checks++;
        if (got_q.size() != FRAME_LEN) begin
            errors++; $display("FAIL rand_len: %0d bytes required %0d", got_q.size(), FRAME_LEN);
        end else begin
            mism = -1;
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i] && mism < 0) mism = i;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL rand_byte: byte %0d=%h required %h", mism, got_q[mism], exp_q[mism]);
            end
        end
        checks++; if (dc != 1) begin errors++; $display("FAIL rand_done_cnt: %0d required 1", dc); end
    endtask

    task automatic test_snapshot();
        int dc, da, mism;
        logic [7:0] want [4];
        want[0] = 8'hEF; want[1] = 8'hBE; want[2] = 8'hAD; want[3] = 8'hDE;
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = $urandom;
        cnt_val[0] = 32'hDEADBEEF;
        build_expected();
        run_frame(70, 1'b1, -1, -1, 1, dc, da);
        checks++;
        if (got_q.size() != FRAME_LEN) begin
            errors++; $display("FAIL snap_len: %0d bytes required %0d", got_q.size(), FRAME_LEN);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_q[2+k] !== want[k]) begin
                    errors++; $display("FAIL snap_cnt0: byte %0d=%h required %h", 2+k, got_q[2+k], want[k]);
                end
            end
            mism = -1;
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i] && mism < 0) mism = i;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL snap_byte: byte %0d=%h required %h", mism, got_q[mism], exp_q[mism]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int dc, da, mism;
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = $urandom;
        build_expected();
        run_frame(100, 1'b0, 10, -1, 1, dc, da);
        checks++;
        if (got_q.size() != FRAME_LEN) begin
            errors++; $display("FAIL restart_len: %0d bytes required %0d", got_q.size(), FRAME_LEN);
        end else begin
            mism = -1;
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i] && mism < 0) mism = i;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL restart_byte: byte %0d=%h required %h", mism, got_q[mism], exp_q[mism]);
            end
        end
        checks++; if (dc != 1) begin errors++; $display("FAIL restart_done_cnt: %0d required 1", dc); end
    endtask

    task automatic test_reset_mid_frame();
        int dc, da, mism;
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = $urandom;
        build_expected();
        run_frame(100, 1'b0, -1, 30, 1, dc, da);
        checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL abort_checksum: %h required 00", checksum); end
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = $urandom;
        build_expected();
        run_frame(60, 1'b0, -1, -1, 1, dc, da);
        checks++;
        if (got_q.size() != FRAME_LEN) begin
            errors++; $display("FAIL after_rst_len: %0d bytes required %0d", got_q.size(), FRAME_LEN);
        end else begin
            checks++;
            if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL after_rst_hdr: %h required a5", got_q[0]); end
            mism = -1;
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i] && mism < 0) mism = i;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL after_rst_byte: byte %0d=%h required %h", mism, got_q[mism], exp_q[mism]);
            end
        end
    endtask

    task automatic test_all_ones();
        int dc, da;
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = 32'hFFFF_FFFF;
        build_expected();
        run_frame(100, 1'b0, -1, -1, 1, dc, da);
        // (0x12 + 72*0xFF) mod 256 = 18378 mod 256 = 202 = 0xCA
        checks++; if (checksum !== 8'hCA) begin errors++; $display("FAIL ones_checksum: %h required ca", checksum); end
        checks++;
        if (got_q.size() != FRAME_LEN) begin
            errors++; $display("FAIL ones_len: %0d bytes required %0d", got_q.size(), FRAME_LEN);
        end else begin
            checks++;
            if (got_q[FRAME_LEN-1] !== 8'hCA) begin
                errors++; $display("FAIL ones_csum_byte: %h required ca", got_q[FRAME_LEN-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc, da, mism;
        logic [7:0] two_q [$];
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = $urandom;
        build_expected();
        two_q = {exp_q, exp_q};
        run_frame(100, 1'b0, -1, -1, 2, dc, da);
        checks++;
        if (got_q.size() != 2*FRAME_LEN) begin
            errors++; $display("FAIL b2b_len: %0d bytes required %0d", got_q.size(), 2*FRAME_LEN);
        end else begin
            mism = -1;
            foreach (two_q[i]) if (got_q[i] !== two_q[i] && mism < 0) mism = i;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL b2b_byte: byte %0d=%h required %h", mism, got_q[mism], two_q[mism]);
            end
        end
        checks++; if (dc != 2) begin errors++; $display("FAIL b2b_done_cnt: %0d required 2", dc); end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) cnt_val[i] = 32'd0;
        test_reset();
        test_basic();
        test_random_ready();
        test_snapshot();
        test_restart_ignored();
        test_reset_mid_frame();
        test_all_ones();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
